// File: rtl/uart_cpld_ctrl.sv
// Buffered bus-to-CPLD UART transfer sequencer.
// CPU reads and writes go to small TX/RX FIFOs. A timed FSM drives the CPLD
// strobes from registered outputs. It paces transmits on the synchronised
// tready flag and drains received bytes on the synchronised data_ready flag.
module uart_cpld_ctrl #(
  parameter int TX_AW     = 2,
  parameter int RX_AW     = 2,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 4,
  parameter int GUARD_CYC = 4
) (
  input  logic        clk_bus,
  input  logic        rst_n,
  input  logic [3:0]  bus_address,
  input  logic [31:0] bus_data_i,
  output logic [31:0] bus_data_o,
  input  logic        bus_read,
  input  logic        bus_write,
  input  logic [7:0]  cpld_data_i,
  output logic [7:0]  cpld_data_o,
  output logic        cpld_data_oe,
  output logic        cpld_wrn,
  output logic        cpld_rdn,
  input  logic        cpld_tready,
  input  logic        cpld_tsre,
  input  logic        cpld_data_ready
);

  localparam int TX_DEPTH = 1 << TX_AW;
  localparam int RX_DEPTH = 1 << RX_AW;

  localparam logic [3:0] ADDR_DATA = 4'h8;
  localparam logic [3:0] ADDR_STAT = 4'hC;

  // Counter reload values: each state runs for (load + 1) cycles.
  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] GUARD_LD = 4'(GUARD_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    RD_PULSE,
    GUARD
  } state_t;

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;

  // Synchronizer vectors, ordered {tready, tsre, data_ready}
  logic [2:0] meta_p0, sync_p1;
  logic       tready_s, tsre_s, ready_s;

  // TX FIFO
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TX_AW:0] tx_wp, tx_rp;
  logic           tx_empty, tx_full, tx_push, tx_pop;
  logic [7:0]     tx_head;

  // RX FIFO
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RX_AW:0] rx_wp, rx_rp;
  logic           rx_empty, rx_full, rx_push, rx_pop, rx_take;
  logic [7:0]     rx_head;

  logic overflow, ovf_set, stat_rd, tx_idle;
  logic unused_bits;

  // Only the low byte of a bus write reaches the transmit path.
  assign unused_bits = ^bus_data_i[31:8];

  // Two-flop synchronizer for the asynchronous CPLD status flags
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      meta_p0 <= {cpld_tready, cpld_tsre, cpld_data_ready};
      sync_p1 <= meta_p0;
    end
  end

  assign tready_s = sync_p1[2];
  assign tsre_s   = sync_p1[1];
  assign ready_s  = sync_p1[0];

  // FIFO flags. Full means the pointer MSBs differ and the index bits match.
  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[TX_AW] != tx_rp[TX_AW]) &&
                    (tx_wp[TX_AW-1:0] == tx_rp[TX_AW-1:0]);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[RX_AW] != rx_rp[RX_AW]) &&
                    (rx_wp[RX_AW-1:0] == rx_rp[RX_AW-1:0]);

  assign tx_head  = tx_mem[tx_rp[TX_AW-1:0]];
  assign rx_head  = rx_mem[rx_rp[RX_AW-1:0]];

  // Accept decisions use the flags from before the edge, so a byte that
  // arrives while its FIFO is full is lost even if a pop happens that cycle.
  assign tx_push  = bus_write && (bus_address == ADDR_DATA) && !tx_full;
  assign rx_pop   = bus_read  && (bus_address == ADDR_DATA) && !rx_empty;
  assign stat_rd  = bus_read  && (bus_address == ADDR_STAT);
  assign rx_push  = rx_take && !rx_full;
  assign ovf_set  = rx_take &&  rx_full;
  assign tx_idle  = tx_empty && (state == IDLE);

  // TX pointer update: bus pushes, FSM pops after a completed write strobe
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
    end
  end

  // TX storage write (data path, not reset)
  always_ff @(posedge clk_bus) begin
    if (tx_push) tx_mem[tx_wp[TX_AW-1:0]] <= bus_data_i[7:0];
  end

  // RX pointer update: FSM pushes the sampled byte, bus reads pop it
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
    end
  end

  // RX storage write. cpld_data_i is sampled on the last read-pulse cycle.
  always_ff @(posedge clk_bus) begin
    if (rx_push) rx_mem[rx_wp[RX_AW-1:0]] <= cpld_data_i;
  end

  // Sticky overflow flag. A new overflow beats a same-cycle status-read clear.
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (stat_rd) begin
      overflow <= 1'b0;
    end
  end

  // Combinational bus read mux
  always_comb begin
    bus_data_o = '0;
    if (bus_read) begin
      case (bus_address)
        ADDR_DATA: bus_data_o = rx_empty ? 32'h0 : {24'h0, rx_head};
        ADDR_STAT: bus_data_o = {27'h0, overflow, tsre_s, tx_idle, !rx_empty, !tx_full};
        default:   bus_data_o = '0;
      endcase
    end
  end

  // FSM state and shared timing counter
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // FSM next state, counter reloads and FIFO handshakes
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    tx_pop     = 1'b0;
    rx_take    = 1'b0;
    case (state)
      IDLE: begin
        if (ready_s) begin
          state_next = RD_PULSE;
          cnt_next   = PULSE_LD;
        end else if (!tx_empty && tready_s) begin
          state_next = WR_SETUP;
          cnt_next   = SETUP_LD;
        end
      end
      WR_SETUP: begin
        if (cnt == 4'd0) begin
          state_next = WR_PULSE;
          cnt_next   = PULSE_LD;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      WR_PULSE: begin
        if (cnt == 4'd0) begin
          state_next = WR_HOLD;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      WR_HOLD: begin
        tx_pop     = 1'b1;
        state_next = GUARD;
        cnt_next   = GUARD_LD;
      end
      RD_PULSE: begin
        if (cnt == 4'd0) begin
          rx_take    = 1'b1;
          state_next = GUARD;
          cnt_next   = GUARD_LD;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      GUARD: begin
        if (cnt == 4'd0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Registered CPLD pins decoded from the next state. This keeps them
  // glitch-free and aligned with the state register.
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      cpld_wrn     <= 1'b1;
      cpld_rdn     <= 1'b1;
      cpld_data_oe <= 1'b0;
      cpld_data_o  <= 8'h00;
    end else begin
      cpld_wrn     <= (state_next != WR_PULSE);
      cpld_rdn     <= (state_next != RD_PULSE);
      cpld_data_oe <= (state_next == WR_SETUP) || (state_next == WR_PULSE) ||
                      (state_next == WR_HOLD);
      if ((state == IDLE) && (state_next == WR_SETUP)) cpld_data_o <= tx_head;
    end
  end

endmodule

// File: tb/tb_uart_cpld_ctrl.sv
// Directed bench for uart_cpld_ctrl with queue-based TX/RX scoreboards.
module tb_uart_cpld_ctrl;

  localparam int SETUP_CYC = 1;
  localparam int PULSE_CYC = 4;
  localparam int GUARD_CYC = 4;

  logic        clk_bus = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  bus_address = 4'h0;
  logic [31:0] bus_data_i = 32'h0;
  logic [31:0] bus_data_o;
  logic        bus_read = 1'b0;
  logic        bus_write = 1'b0;
  logic [7:0]  cpld_data_i = 8'h00;
  logic [7:0]  cpld_data_o;
  logic        cpld_data_oe;
  logic        cpld_wrn;
  logic        cpld_rdn;
  logic        cpld_tready = 1'b1;
  logic        cpld_tsre = 1'b1;
  logic        cpld_data_ready = 1'b0;

  int   errors = 0;
  int   checks = 0;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic       ovf_m = 1'b0;

  always #5 clk_bus = ~clk_bus;

  uart_cpld_ctrl #(
    .TX_AW(2), .RX_AW(2),
    .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC), .GUARD_CYC(GUARD_CYC)
  ) dut (
    .clk_bus(clk_bus),
    .rst_n(rst_n),
    .bus_address(bus_address),
    .bus_data_i(bus_data_i),
    .bus_data_o(bus_data_o),
    .bus_read(bus_read),
    .bus_write(bus_write),
    .cpld_data_i(cpld_data_i),
    .cpld_data_o(cpld_data_o),
    .cpld_data_oe(cpld_data_oe),
    .cpld_wrn(cpld_wrn),
    .cpld_rdn(cpld_rdn),
    .cpld_tready(cpld_tready),
    .cpld_tsre(cpld_tsre),
    .cpld_data_ready(cpld_data_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Strobe safety is checked on every cycle outside reset.
  always @(negedge clk_bus) begin
    if (rst_n === 1'b1) begin
      chk("strobe_excl", {31'h0, (cpld_wrn | cpld_rdn)}, 32'h1);
      chk("oe_vs_rdn", {31'h0, !(cpld_data_oe && !cpld_rdn)}, 32'h1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk_bus);
    bus_address = a;
    bus_data_i  = d;
    bus_write   = 1'b1;
    @(negedge clk_bus);
    bus_write   = 1'b0;
    bus_address = 4'h0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk_bus);
    bus_address = a;
    bus_read    = 1'b1;
    #1 d = bus_data_o;
    @(negedge clk_bus);
    bus_read    = 1'b0;
    bus_address = 4'h0;
  endtask

  // Push to the TX scoreboard only if the 4-entry FIFO model has room.
  task automatic wr_byte(input logic [7:0] b);
    if (txq.size() < 4) txq.push_back(b);
    bus_wr(4'h8, {24'h0, b});
  endtask

  task automatic check_status(input string tag);
    logic [31:0] d;
    logic [31:0] exp;
    exp = {27'h0, ovf_m, 1'b1, (txq.size() == 0), (rxq.size() != 0), (txq.size() < 4)};
    bus_rd(4'hC, d);
    chk(tag, d, exp);
    ovf_m = 1'b0;
  endtask

  task automatic check_rx_read(input string tag);
    logic [31:0] d;
    logic [31:0] exp;
    exp = (rxq.size() != 0) ? {24'h0, rxq.pop_front()} : 32'h0;
    bus_rd(4'h8, d);
    chk(tag, d, exp);
  endtask

  // Follow one complete write strobe and compare the byte with the TX scoreboard.
  task automatic expect_write(input string tag, input int exp_lat);
    int n;
    logic [7:0] exp;
    n = 0;
    while (cpld_data_oe !== 1'b1 && n < 200) begin
      @(negedge clk_bus);
      n++;
    end
    chk({tag, "_timeout"}, {31'h0, (n < 200)}, 32'h1);
    if (exp_lat >= 0) chk({tag, "_latency"}, n, exp_lat);
    exp = (txq.size() != 0) ? txq.pop_front() : 8'h00;
    chk({tag, "_data"}, {24'h0, cpld_data_o}, {24'h0, exp});
    n = 0;
    while (cpld_wrn === 1'b1 && cpld_data_oe === 1'b1 && n < 20) begin
      @(negedge clk_bus);
      n++;
    end
    chk({tag, "_setup"}, n, SETUP_CYC);
    n = 0;
    while (cpld_wrn === 1'b0 && n < 20) begin
      @(negedge clk_bus);
      n++;
    end
    chk({tag, "_pulse"}, n, PULSE_CYC);
    chk({tag, "_hold_oe"}, {31'h0, cpld_data_oe}, 32'h1);
    chk({tag, "_hold_data"}, {24'h0, cpld_data_o}, {24'h0, exp});
    @(negedge clk_bus);
    chk({tag, "_guard_oe"}, {31'h0, cpld_data_oe}, 32'h0);
  endtask

  // Offer one byte on data_ready and follow the read strobe.
  task automatic expect_read(input string tag, input logic [7:0] b);
    int n;
    cpld_data_i     = b;
    cpld_data_ready = 1'b1;
    n = 0;
    while (cpld_rdn !== 1'b0 && n < 50) begin
      @(negedge clk_bus);
      n++;
    end
    chk({tag, "_timeout"}, {31'h0, (n < 50)}, 32'h1);
    chk({tag, "_oe"}, {31'h0, cpld_data_oe}, 32'h0);
    cpld_data_ready = 1'b0;
    n = 0;
    while (cpld_rdn === 1'b0 && n < 20) begin
      @(negedge clk_bus);
      n++;
    end
    chk({tag, "_pulse"}, n, PULSE_CYC);
    if (rxq.size() < 4) rxq.push_back(b);
    else ovf_m = 1'b1;
    repeat (GUARD_CYC + 2) @(negedge clk_bus);
  endtask

  initial begin
    logic [31:0] d;
    int n;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk_bus);
    chk("rst_wrn", {31'h0, cpld_wrn}, 32'h1);
    chk("rst_rdn", {31'h0, cpld_rdn}, 32'h1);
    chk("rst_oe", {31'h0, cpld_data_oe}, 32'h0);
    chk("rst_data_o", {24'h0, cpld_data_o}, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_bus);
    chk("idle_bus_o", bus_data_o, 32'h0);
    bus_rd(4'hC, d);
    chk("rst_status", d, 32'h0000000D);
    bus_rd(4'h4, d);
    chk("other_addr", d, 32'h0);
    check_rx_read("rx_empty_rd");

    // Single transmit with exact timing
    wr_byte(8'h5A);
    expect_write("wr5a", 1);
    repeat (GUARD_CYC + 2) @(negedge clk_bus);
    check_status("wr5a_status");

    // Fill TX with tready low; fifth byte is dropped
    cpld_tready = 1'b0;
    repeat (4) @(negedge clk_bus);
    for (int i = 1; i <= 4; i++) wr_byte(8'(i));
    check_status("tx_full_status");
    wr_byte(8'h05);
    check_status("tx_drop_status");
    cpld_tready = 1'b1;
    for (int i = 0; i < 4; i++) expect_write("burst", -1);
    repeat (GUARD_CYC + 4) @(negedge clk_bus);
    check_status("burst_done_status");

    // Single receive
    expect_read("rda7", 8'hA7);
    check_status("rx_nempty_status");
    check_rx_read("rda7_data");
    check_status("rx_drained_status");

    // Five receives, one overflows
    for (int i = 0; i < 5; i++) expect_read("rx5", 8'h10 + 8'(i));
    check_status("ovf_status1");
    check_status("ovf_status2");
    for (int i = 0; i < 4; i++) check_rx_read("rx5_data");
    check_rx_read("rx5_empty");
    check_status("rx5_final_status");

    // RX has priority over a pending TX byte
    cpld_tready = 1'b0;
    repeat (4) @(negedge clk_bus);
    wr_byte(8'h33);
    cpld_data_i     = 8'hC4;
    cpld_tready     = 1'b1;
    cpld_data_ready = 1'b1;
    n = 0;
    while (cpld_rdn === 1'b1 && cpld_wrn === 1'b1 && n < 50) begin
      @(negedge clk_bus);
      n++;
    end
    chk("prio_rdn_first", {31'h0, cpld_rdn}, 32'h0);
    chk("prio_wrn_high", {31'h0, cpld_wrn}, 32'h1);
    cpld_data_ready = 1'b0;
    n = 0;
    while (cpld_rdn === 1'b0 && n < 20) begin
      @(negedge clk_bus);
      n++;
    end
    chk("prio_rd_pulse", n, PULSE_CYC);
    rxq.push_back(8'hC4);
    expect_write("prio_wr", -1);
    repeat (GUARD_CYC + 4) @(negedge clk_bus);
    check_status("prio_status");
    check_rx_read("prio_rx_data");

    // Reset in the middle of a write pulse
    wr_byte(8'h77);
    n = 0;
    while (cpld_wrn !== 1'b0 && n < 50) begin
      @(negedge clk_bus);
      n++;
    end
    chk("mid_rst_reach_pulse", {31'h0, cpld_wrn}, 32'h0);
    @(negedge clk_bus);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_wrn", {31'h0, cpld_wrn}, 32'h1);
    chk("mid_rst_oe", {31'h0, cpld_data_oe}, 32'h0);
    chk("mid_rst_data_o", {24'h0, cpld_data_o}, 32'h0);
    txq.delete();
    rxq.delete();
    ovf_m = 1'b0;
    repeat (2) @(negedge clk_bus);
    rst_n = 1'b1;
    repeat (4) @(negedge clk_bus);
    check_status("mid_rst_status");
    repeat (20) @(negedge clk_bus);
    chk("mid_rst_no_wr", {31'h0, cpld_wrn}, 32'h1);
    chk("mid_rst_no_oe", {31'h0, cpld_data_oe}, 32'h0);
    check_rx_read("mid_rst_rx_empty");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
